// File: rtl/adder_serial_param.sv
// Digit-serial adder/subtractor. Operands are latched on a valid/ready
// handshake and summed DIGIT bits per clock, least significant digit first,
// through a single DIGIT-bit adder slice. Sum and flags are held in DONE
// until the consumer takes them.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for operands, in_ready high
// RUN   | one digit per clock, counter selects the sum digit written
// DONE  | result and flags held, out_valid high until out_ready
module adder_serial_param #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             carry_out_q;
    logic             overflow_q;
    logic             zero_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [DIGIT:0]   slice;
    logic [DIGIT-1:0] dig_s;
    logic             dig_c;
    logic             c_msb_in;

    // Digit slice: operands are shifted down each cycle so the active digit
    // always sits in the low DIGIT bits; the result digit is placed by counter.
    always_comb begin
        slice    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, carry_q};
        dig_s    = slice[DIGIT-1:0];
        dig_c    = slice[DIGIT];
        // carry into the top bit of the slice; on the last digit this is the
        // carry into the word MSB (equals carry_q when DIGIT is 1)
        c_msb_in = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dig_s[DIGIT-1];
        sum_d    = sum_q;
        for (int k = 0; k < N; k++) begin
            if (cnt_q == CW'(k)) begin
                sum_d[k*DIGIT +: DIGIT] = dig_s;
            end
        end
    end

    // Control FSM with registered handshake outputs and result flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= in1;
                        b_q        <= sub ? ~in2 : in2;
                        carry_q    <= sub | carry_in;
                        cnt_q      <= '0;
                        sum_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    carry_q <= dig_c;
                    sum_q   <= sum_d;
                    if (cnt_q == LAST) begin
                        carry_out_q <= dig_c;
                        overflow_q  <= c_msb_in ^ dig_c;
                        zero_q      <= (sum_d == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_adder_serial_param.sv
// Bench for adder_serial_param: four instances cover (WIDTH,DIGIT) =
// (8,2), (8,1), (8,8), (16,4); results are compared with a signed/unsigned
// arithmetic reference model.
module tb_adder_serial_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in1 = '0;
    logic [15:0] in2 = '0;
    logic        carry_in = 1'b0;
    logic        sub = 1'b0;
    logic [3:0]  ivld = '0;
    logic [3:0]  ordy = '0;
    logic [3:0]  irdy;
    logic [3:0]  ovld;
    logic [3:0]  cout;
    logic [3:0]  ovfl;
    logic [3:0]  zf;
    logic [7:0]  sum0, sum1, sum2;
    logic [15:0] sum3;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    int wid [4] = '{8, 8, 8, 16};
    int lat [4] = '{4, 8, 1, 4};

    longint e_sum;
    bit     e_co, e_ov, e_z;

    always #5 clk = ~clk;

    adder_serial_param #(.WIDTH(8), .DIGIT(2)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(ivld[0]), .in_ready(irdy[0]),
        .in1(in1[7:0]), .in2(in2[7:0]), .carry_in(carry_in), .sub(sub),
        .out_valid(ovld[0]), .out_ready(ordy[0]), .sum(sum0),
        .carry_out(cout[0]), .overflow(ovfl[0]), .zero(zf[0]));
    adder_serial_param #(.WIDTH(8), .DIGIT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(ivld[1]), .in_ready(irdy[1]),
        .in1(in1[7:0]), .in2(in2[7:0]), .carry_in(carry_in), .sub(sub),
        .out_valid(ovld[1]), .out_ready(ordy[1]), .sum(sum1),
        .carry_out(cout[1]), .overflow(ovfl[1]), .zero(zf[1]));
    adder_serial_param #(.WIDTH(8), .DIGIT(8)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(ivld[2]), .in_ready(irdy[2]),
        .in1(in1[7:0]), .in2(in2[7:0]), .carry_in(carry_in), .sub(sub),
        .out_valid(ovld[2]), .out_ready(ordy[2]), .sum(sum2),
        .carry_out(cout[2]), .overflow(ovfl[2]), .zero(zf[2]));
    adder_serial_param #(.WIDTH(16), .DIGIT(4)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(ivld[3]), .in_ready(irdy[3]),
        .in1(in1), .in2(in2), .carry_in(carry_in), .sub(sub),
        .out_valid(ovld[3]), .out_ready(ordy[3]), .sum(sum3),
        .carry_out(cout[3]), .overflow(ovfl[3]), .zero(zf[3]));

    function automatic logic [15:0] sum_of(input int idx);
        case (idx)
            0:       return {8'h00, sum0};
            1:       return {8'h00, sum1};
            2:       return {8'h00, sum2};
            default: return sum3;
        endcase
    endfunction

    // Reference: plain unsigned sum for result/carry, signed range test for overflow.
    function automatic void model(input int w, input longint a, input longint b,
                                  input bit cin, input bit sb, output longint s,
                                  output bit co, output bit ov, output bit z);
        longint m    = (longint'(1) << w) - 1;
        longint half = longint'(1) << (w - 1);
        longint bp, tot, sa, sbv, sr;
        bp  = sb ? (~b & m) : b;
        tot = a + bp + (sb ? 1 : longint'(cin));
        s   = tot & m;
        co  = ((tot >> w) & 1) != 0;
        sa  = (a >= half) ? a - (m + 1) : a;
        sbv = (b >= half) ? b - (m + 1) : b;
        sr  = sb ? sa - sbv : sa + sbv + longint'(cin);
        ov  = (sr >= half) || (sr < -half);
        z   = (s == 0);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                         input bit cin, input bit sb, input bit rel, input string tag);
        int     n;
        longint m;
        m = (longint'(1) << wid[idx]) - 1;
        model(wid[idx], longint'(a) & m, longint'(b) & m, cin, sb, e_sum, e_co, e_ov, e_z);
        chk({tag, ".in_ready"}, 64'(irdy[idx]), 64'd1);
        in1 = a; in2 = b; carry_in = cin; sub = sb;
        ivld[idx] = 1'b1;
        @(posedge clk); #1;
        ivld[idx] = 1'b0;
        in1 = 16'($urandom); in2 = 16'($urandom);
        carry_in = 1'($urandom); sub = 1'($urandom);
        n = 0;
        while (!ovld[idx] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".latency"}, 64'(n), 64'(lat[idx]));
        chk({tag, ".sum"}, 64'(sum_of(idx)), 64'(e_sum));
        chk({tag, ".carry_out"}, 64'(cout[idx]), 64'(e_co));
        chk({tag, ".overflow"}, 64'(ovfl[idx]), 64'(e_ov));
        chk({tag, ".zero"}, 64'(zf[idx]), 64'(e_z));
        if (rel) begin
            ordy[idx] = 1'b1;
            @(posedge clk); #1;
            ordy[idx] = 1'b0;
            chk({tag, ".ready_after"}, 64'(irdy[idx]), 64'd1);
            chk({tag, ".valid_after"}, 64'(ovld[idx]), 64'd0);
        end
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic [15:0] hold_sum;
        bit          rc, rs;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // start an op, then reset in the middle of RUN
        in1 = 16'h00AA; in2 = 16'h0055; ivld[0] = 1'b1;
        @(posedge clk); #1;
        ivld[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst.in_ready", 64'(irdy[0]), 64'd1);
        chk("rst.out_valid", 64'(ovld[0]), 64'd0);
        chk("rst.sum", 64'(sum_of(0)), 64'd0);
        chk("rst.flags", 64'({cout[0], ovfl[0], zf[0]}), 64'd0);
        repeat (4) @(posedge clk);
        #1 chk("rst.no_partial", 64'(ovld[0]), 64'd0);
        do_op(0, 16'h12, 16'h34, 1'b0, 1'b0, 1'b1, "post_rst");

        // directed corner cases
        do_op(0, 16'h7F, 16'h01, 1'b0, 1'b0, 1'b1, "add_ovf");
        do_op(0, 16'hFF, 16'h01, 1'b1, 1'b0, 1'b1, "add_wrap");
        do_op(0, 16'h05, 16'h07, 1'b1, 1'b1, 1'b1, "sub_borrow");
        do_op(0, 16'h80, 16'h01, 1'b0, 1'b1, 1'b1, "sub_ovf");
        do_op(0, 16'h33, 16'h33, 1'b0, 1'b1, 1'b1, "sub_zero");

        // backpressure with in_valid held and operands changing
        do_op(0, 16'hC3, 16'h5A, 1'b1, 1'b0, 1'b0, "bp");
        hold_sum = 16'(e_sum);
        for (int i = 0; i < 10; i++) begin
            ivld[0] = 1'b1;
            in1 = 16'($urandom); in2 = 16'($urandom);
            @(posedge clk); #1;
            chk("bp.sum", 64'(sum_of(0)), 64'(hold_sum));
            chk("bp.flags", 64'({cout[0], ovfl[0], zf[0]}), 64'({e_co, e_ov, e_z}));
            chk("bp.in_ready", 64'(irdy[0]), 64'd0);
            chk("bp.out_valid", 64'(ovld[0]), 64'd1);
        end
        ivld[0] = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        chk("bp.release_ready", 64'(irdy[0]), 64'd1);
        chk("bp.idle_hold", 64'(sum_of(0)), 64'(hold_sum));
        do_op(0, 16'h01, 16'h02, 1'b0, 1'b0, 1'b1, "post_bp");

        // randomized sweep over all four parameter sets
        for (int d = 0; d < 4; d++) begin
            for (int i = 0; i < ((d == 0) ? 200 : 1000); i++) begin
                ra = 16'($urandom); rb = 16'($urandom);
                rc = 1'($urandom);  rs = 1'($urandom);
                if (i % 16 == 0) ra = '1;
                if (i % 16 == 1) rb = ra;
                do_op(d, ra, rb, rc, rs, 1'b1, $sformatf("rnd%0d", d));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
